// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among NUM_REQ requesters,
// with a clear sequencer that zeroes every register through the same port.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic                         clear_start,
    output logic                         clear_busy,
    output logic                         clear_done,
    output logic                         write,
    output logic [ADDR_W-1:0]            dr,
    output logic [DATA_W-1:0]            write_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [PtrW-1:0]   grant_q, grant_d;
    logic              done_q, done_d;

    logic              gnt_found;
    logic [PtrW-1:0]   gnt_idx;
    logic [PtrW-1:0]   idx;

    // Scan from ptr upward (mod NUM_REQ); first valid requester wins.
    // clear_start suppresses all grants so it takes precedence.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        if (state_q == StIdle && !clear_start) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PtrW'((32'(ptr_q) + 32'(k)) % NUM_REQ);
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        write_d = 1'b0;
        dr_d    = dr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        if (state_q == StClear) begin
            write_d = 1'b1;
            dr_d    = cnt_q;
            wdata_d = '0;
            grant_d = '0;
            if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear_start) begin
            state_d = StClear;
            cnt_d   = '0;
        end else if (gnt_found) begin
            write_d = 1'b1;
            dr_d    = req_addr[gnt_idx*ADDR_W +: ADDR_W];
            wdata_d = req_data[gnt_idx*DATA_W +: DATA_W];
            grant_d = gnt_idx;
            ptr_d   = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            dr_q    <= '0;
            wdata_q <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            dr_q    <= dr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign clear_busy = (state_q == StClear);
    assign clear_done = done_q;
    assign write      = write_q;
    assign dr         = dr_q;
    assign write_data = wdata_q;
    assign grant_id   = grant_q;

endmodule
